// File: rtl/stf_seq_pkg.sv
// Shared tx definitions for the L-STF burst sequencer: widths, period length and
// the sequencer state encoding.
package stf_seq_pkg;

  localparam int STF_LEN = 16;
  localparam int IQ_W    = 32;
  localparam int CNT_W   = 8;
  localparam int HALF_W  = IQ_W / 2;
  localparam int ADDR_W  = $clog2(STF_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage : stf_seq_pkg

// File: rtl/stf_iq_half.sv
// Optional edge window for the L-STF burst: halves I and Q independently when en is
// high, otherwise passes the word through. Only present when STF_WINDOW_EN is defined.
`ifdef STF_WINDOW_EN
module stf_iq_half
  import stf_seq_pkg::*;
(
  input  logic            en,
  input  logic [IQ_W-1:0] din,
  output logic [IQ_W-1:0] dout
);

  logic signed [HALF_W-1:0] i_in;
  logic signed [HALF_W-1:0] q_in;
  logic signed [HALF_W-1:0] i_half;
  logic signed [HALF_W-1:0] q_half;

  // Arithmetic shift keeps the sign, so negative components round toward -inf.
  function automatic logic signed [HALF_W-1:0] half_s(input logic signed [HALF_W-1:0] x);
    return x >>> 1;
  endfunction

  assign i_in   = din[IQ_W-1:HALF_W];
  assign q_in   = din[HALF_W-1:0];
  assign i_half = half_s(i_in);
  assign q_half = half_s(q_in);

  assign dout = en ? {i_half, q_half} : din;

endmodule : stf_iq_half
`endif

// File: rtl/stf_seq.sv
// L-STF burst sequencer: streams NUM_REP periods of a 16-word external ROM through a
// valid/ready output register. Build option STF_WINDOW_EN halves the first/last sample.
module stf_seq
  import stf_seq_pkg::*;
#(
  parameter int NUM_REP = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IQ_W-1:0]   rom_dout,
  output logic [IQ_W-1:0]   out_iq,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int                LAST_I   = NUM_REP * STF_LEN - 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(LAST_I);

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   sample_cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic [IQ_W-1:0]    iq_n;
  logic               vld_n;
  logic               last_n;
  logic               busy_n;
  logic               done_n;
  logic               load;
  logic [IQ_W-1:0]    sample_p0;

  // sample_cnt always points at the next sample to load, so the ROM word is ready
  // combinationally on the edge that captures it.
  assign rom_addr = sample_cnt[ADDR_W-1:0];

`ifdef STF_WINDOW_EN
  logic edge_smp;

  assign edge_smp = (sample_cnt == '0) || (sample_cnt == LAST_IDX);

  stf_iq_half u_half (
    .en   (edge_smp),
    .din  (rom_dout),
    .dout (sample_p0)
  );
`else
  assign sample_p0 = rom_dout;
`endif

  assign load = !out_valid || out_ready;

  always_comb begin
    state_n = state;
    cnt_n   = sample_cnt;
    iq_n    = out_iq;
    vld_n   = out_valid;
    last_n  = out_last;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        // A start coinciding with the done pulse belongs to the finished burst.
        if (start && !done) begin
          iq_n    = sample_p0;
          vld_n   = 1'b1;
          last_n  = 1'b0;
          busy_n  = 1'b1;
          cnt_n   = CNT_W'(1);
          state_n = RUN;
        end
      end
      RUN: begin
        if (load) begin
          iq_n  = sample_p0;
          vld_n = 1'b1;
          if (sample_cnt == LAST_IDX) begin
            last_n  = 1'b1;
            state_n = FLUSH;
          end else begin
            cnt_n = sample_cnt + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        if (out_ready) begin
          vld_n   = 1'b0;
          last_n  = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        vld_n   = 1'b0;
        last_n  = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // Output register stage: everything the downstream sees is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      out_iq     <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      sample_cnt <= cnt_n;
      out_iq     <= iq_n;
      out_valid  <= vld_n;
      out_last   <= last_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule : stf_seq

// File: tb/tb_stf_seq.sv
// Self-checking bench for stf_seq: a NUM_REP=10 instance for bursts, stalls, start
// filtering and reset, and a NUM_REP=1 instance for the held-first-sample case.
module tb_stf_seq;

  localparam int NT   = 160;
  localparam int NT1  = 16;
  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  rom_addr;
  logic [31:0] rom_dout;
  logic [31:0] out_iq;
  logic        out_valid, out_last, busy, done;

  logic        start1 = 1'b0;
  logic        ready1 = 1'b0;
  logic [3:0]  rom_addr1;
  logic [31:0] rom_dout1;
  logic [31:0] out_iq1;
  logic        out_valid1, out_last1, busy1, done1;

  logic [31:0] rom [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rom_dout  = rom[rom_addr];
  assign rom_dout1 = rom[rom_addr1];

  stf_seq #(.NUM_REP(10)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .out_iq(out_iq), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  stf_seq #(.NUM_REP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rom_addr(rom_addr1), .rom_dout(rom_dout1),
    .out_iq(out_iq1), .out_valid(out_valid1), .out_ready(ready1), .out_last(out_last1),
    .busy(busy1), .done(done1)
  );

  // Reference: burst sample idx is ROM word idx mod 16; the windowed build halves
  // I and Q (floor division by 2) of the first and last sample of the burst.
  function automatic logic [31:0] exp_word(input int idx, input int n);
    logic [31:0] w;
    int i, q;
    w = rom[idx % 16];
    i = 0;
    q = 0;
`ifdef STF_WINDOW_EN
    if (idx == 0 || idx == n - 1) begin
      i = int'($signed(w[31:16]));
      q = int'($signed(w[15:0]));
      i = i >>> 1;
      q = q >>> 1;
      w = {i[15:0], q[15:0]};
    end
`endif
    return w;
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    int p;
    p = (cyc - 1) % 4;
    if (mode == 0) return 1'b1;
    if (mode == 1) return (p == 0 || p == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_iq !== 0 || out_valid !== 0 || out_last !== 0 || busy !== 0 || done !== 0 || rom_addr !== 0) begin
      errors++;
      $display("FAIL reset_dut got iq=%h v=%b l=%b b=%b d=%b a=%h exp all 0", out_iq, out_valid, out_last, busy, done, rom_addr);
    end
    checks++;
    if (out_iq1 !== 0 || out_valid1 !== 0 || out_last1 !== 0 || busy1 !== 0 || done1 !== 0 || rom_addr1 !== 0) begin
      errors++;
      $display("FAIL reset_dut1 got iq=%h v=%b l=%b b=%b d=%b a=%h exp all 0", out_iq1, out_valid1, out_last1, busy1, done1, rom_addr1);
    end
    rst = 1'b0;
  endtask

  // mode: 0 = ready always high, 1 = ready pattern 1,0,0,1, 2 = random ready.
  task automatic run_burst(input string name, input int mode, input bit spam);
    int k;
    bit got_done;
    bit prev_stall;
    logic [31:0] prev_iq;
    logic prev_last;
    k = 0;
    got_done = 1'b0;
    prev_stall = 1'b0;
    prev_iq = '0;
    prev_last = 1'b0;
    @(negedge clk);
    checks++;
    if (rom_addr !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_pre got addr=%h busy=%b exp addr=0 busy=0", name, rom_addr, busy);
    end
    start = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= BUDGET && !got_done; cyc++) begin
      @(negedge clk);
      start = spam && (cyc == 5 || cyc == 50);
      if (prev_stall) begin
        checks++;
        if (out_iq !== prev_iq || out_valid !== 1'b1 || out_last !== prev_last) begin
          errors++;
          $display("FAIL %s stall_hold cyc=%0d got iq=%h v=%b l=%b exp iq=%h v=1 l=%b", name, cyc, out_iq, out_valid, out_last, prev_iq, prev_last);
        end
      end
      if (done) begin
        got_done = 1'b1;
        checks++;
        if (k !== NT) begin
          errors++;
          $display("FAIL %s transfer_count got %0d exp %0d", name, k, NT);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
          errors++;
          $display("FAIL %s idle_after_done got b=%b v=%b l=%b exp 0 0 0", name, busy, out_valid, out_last);
        end
        if (mode == 0) begin
          checks++;
          if (cyc !== NT + 1) begin
            errors++;
            $display("FAIL %s latency got %0d exp %0d", name, cyc, NT + 1);
          end
        end
      end else begin
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_valid cyc=%0d got b=%b v=%b exp 1 1", name, cyc, busy, out_valid);
        end
        out_ready = ready_for(mode, cyc);
        if (out_valid && out_ready) begin
          checks++;
          if (out_iq !== exp_word(k, NT)) begin
            errors++;
            $display("FAIL %s data k=%0d got %h exp %h", name, k, out_iq, exp_word(k, NT));
          end
          checks++;
          if (out_last !== (k == NT - 1)) begin
            errors++;
            $display("FAIL %s last k=%0d got %b exp %b", name, k, out_last, (k == NT - 1));
          end
          if (k + 1 < NT) begin
            checks++;
            if (rom_addr !== 4'((k + 1) % 16)) begin
              errors++;
              $display("FAIL %s rom_addr k=%0d got %h exp %h", name, k, rom_addr, 4'((k + 1) % 16));
            end
          end
          k++;
        end
        prev_stall = out_valid && !out_ready;
        prev_iq = out_iq;
        prev_last = out_last;
      end
    end
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL %s timeout got no done exp done within %0d cycles", name, BUDGET);
    end
    start = spam;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s post_done got d=%b b=%b v=%b exp 0 0 0", name, done, busy, out_valid);
    end
  endtask

  task automatic test_continuous();
    run_burst("continuous", 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_burst("backpressure", 1, 1'b0);
  endtask

  task automatic test_random_ready();
    run_burst("random_ready", 2, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_burst("start_ignored", 0, 1'b1);
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    repeat (73) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_iq !== 0 || out_valid !== 0 || out_last !== 0 || busy !== 0 || done !== 0 || rom_addr !== 0) begin
      errors++;
      $display("FAIL rst_mid got iq=%h v=%b l=%b b=%b d=%b a=%h exp all 0", out_iq, out_valid, out_last, busy, done, rom_addr);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_quiet c=%0d got d=%b b=%b exp 0 0", c, done, busy);
      end
    end
    run_burst("after_rst", 0, 1'b0);
  endtask

  task automatic test_rep1_hold();
    int k;
    bit got_done;
    k = 0;
    got_done = 1'b0;
    @(negedge clk);
    start1 = 1'b1;
    ready1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      checks++;
      if (out_valid1 !== 1'b1 || busy1 !== 1'b1 || out_iq1 !== exp_word(0, NT1) || out_last1 !== 1'b0) begin
        errors++;
        $display("FAIL rep1_hold c=%0d got iq=%h v=%b b=%b l=%b exp iq=%h v=1 b=1 l=0", c, out_iq1, out_valid1, busy1, out_last1, exp_word(0, NT1));
      end
    end
`ifdef STF_WINDOW_EN
    checks++;
    if (out_iq1 !== 32'h0179_0179) begin
      errors++;
      $display("FAIL window_first got %h exp 01790179", out_iq1);
    end
`endif
    ready1 = 1'b1;
    for (int c = 0; c < 100 && !got_done; c++) begin
      if (done1) begin
        got_done = 1'b1;
      end else if (out_valid1) begin
        checks++;
        if (out_iq1 !== exp_word(k, NT1) || out_last1 !== (k == NT1 - 1)) begin
          errors++;
          $display("FAIL rep1_data k=%0d got iq=%h l=%b exp iq=%h l=%b", k, out_iq1, out_last1, exp_word(k, NT1), (k == NT1 - 1));
        end
`ifdef STF_WINDOW_EN
        if (k == NT1 - 1) begin
          checks++;
          if (out_iq1 !== 32'h0179_fe87) begin
            errors++;
            $display("FAIL window_last got %h exp 0179fe87", out_iq1);
          end
        end
`endif
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (!got_done || k !== NT1) begin
      errors++;
      $display("FAIL rep1_done got done=%b transfers=%0d exp done=1 transfers=%0d", got_done, k, NT1);
    end
    ready1 = 1'b0;
  endtask

  initial begin
    rom[0] = 32'h02f2_02f2;
    for (int i = 1; i < 15; i++) rom[i] = $urandom;
    rom[15] = 32'h02f2_fd0e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_continuous();
    test_backpressure();
    test_random_ready();
    test_start_ignored();
    test_rst_mid();
    test_rep1_hold();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_stf_seq
